// File: rtl/pixel_stream_bridge.sv
// rtl/pixel_stream_bridge.sv - show-ahead pixel FIFO with raster position tracking
// Head pixel coordinate counters advance only on pops; flush clears all state except frame_idx.
module pixel_stream_bridge #(
   parameter int PIXEL_W = 24,
   parameter int DEPTH   = 16,
   parameter int H_RES   = 320,
   parameter int V_RES   = 240
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [PIXEL_W-1:0]         in_data_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [PIXEL_W-1:0]         out_data_o,
   output logic                       out_sof_o,
   output logic                       out_eol_o,
   output logic                       frame_idx_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       underrun_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);

   logic [PIXEL_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [LW-1:0]      level;
   logic [XW-1:0]      x;
   logic [YW-1:0]      y;
   logic               frame_idx, underrun;
   logic               push, pop, line_end, frame_end, at_origin;

   assign in_ready_o  = (level != LVL_FULL) && !flush_i;
   assign out_valid_o = (level != '0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;
   assign line_end    = (x == X_LAST);
   assign frame_end   = line_end && (y == Y_LAST);
   assign at_origin   = (x == '0) && (y == '0);

   assign out_data_o  = mem[rd_ptr];
   assign out_sof_o   = at_origin && out_valid_o;
   assign out_eol_o   = line_end && out_valid_o;
   assign frame_idx_o = frame_idx;
   assign level_o     = level;
   assign underrun_o  = underrun;

   // Storage is left uncleared; level and pointers alone decide what is valid.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= in_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         x         <= '0;
         y         <= '0;
         frame_idx <= 1'b0;
         underrun  <= 1'b0;
      end else if (flush_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         x         <= '0;
         y         <= '0;
         underrun  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (pop) begin
            if (line_end) begin
               x <= '0;
               if (frame_end) begin
                  y         <= '0;
                  frame_idx <= ~frame_idx;
               end else begin
                  y <= y + 1'b1;
               end
            end else begin
               x <= x + 1'b1;
            end
         end
         // Display asked for a pixel mid-frame and none was there.
         if (out_ready_i && !out_valid_o && !at_origin) underrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pixel_stream_bridge.sv
// tb/tb_pixel_stream_bridge.sv - directed self-checking bench for pixel_stream_bridge
// Runs with DEPTH=16, H_RES=4, V_RES=2 so fill and frame boundaries are short.
module tb_pixel_stream_bridge;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [23:0] in_data, out_data;
   logic        sof, eol, frame_idx, underrun;
   logic [4:0]  level;
   int          checks = 0;
   int          errors = 0;

   pixel_stream_bridge #(.PIXEL_W(24), .DEPTH(16), .H_RES(4), .V_RES(2)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_sof_o(sof), .out_eol_o(eol), .frame_idx_o(frame_idx),
      .level_o(level), .underrun_o(underrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick(); tick();
      check("rst_level", level, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sof", sof, 0);
      check("rst_eol", eol, 0);
      check("rst_frame", frame_idx, 0);
      check("rst_underrun", underrun, 0);
      flush = 1'b1; #1;
      check("rst_in_ready_flush", in_ready, 0);
      flush = 1'b0;
      rst = 1'b0;
      tick();

      // Fill 16 entries with the display stalled.
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 24'h100 + 24'(i);
         tick();
      end
      check("fill_level", level, 16);
      check("fill_in_ready", in_ready, 0);
      check("fill_head", out_data, 24'h100);
      check("fill_sof", sof, 1);
      in_data = 24'h1ff;
      tick(); tick();
      check("fill_17th_held", level, 16);

      // Push and pop together while full: only the pop happens.
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("full_pp_level", level, 15);
      check("full_pp_in_ready", in_ready, 1);
      check("full_pp_head", out_data, 24'h101);

      for (int i = 1; i < 16; i++) begin
         check("drain_order", out_data, 24'h100 + 24'(i));
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      check("drain_level", level, 0);
      check("drain_out_valid", out_valid, 0);
      check("drain_frame", frame_idx, 0);
      check("drain_underrun", underrun, 0);

      // Level 5 with simultaneous push and pop.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 24'h200 + 24'(i);
         tick();
      end
      check("lvl5_level", level, 5);
      in_data = 24'h205; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("lvl5_pp_level", level, 5);
      check("lvl5_pp_head", out_data, 24'h201);

      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush1_level", level, 0);
      check("flush1_underrun", underrun, 0);

      // One full 4x2 frame.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 24'h500 + 24'(i);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("f1_data", out_data, 24'h500 + 24'(i));
         check("f1_sof", sof, (i == 0) ? 1 : 0);
         check("f1_eol", eol, (i == 3 || i == 7) ? 1 : 0);
         check("f1_frame", frame_idx, 0);
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      check("f1_frame_toggled", frame_idx, 1);
      check("f1_underrun", underrun, 0);

      // Flush beats a push and a pop at level 3.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 24'h600 + 24'(i);
         tick();
      end
      check("fp_level3", level, 3);
      in_data = 24'h6aa; out_ready = 1'b1; flush = 1'b1;
      #1;
      check("fp_in_ready", in_ready, 0);
      tick();
      flush = 1'b0; out_ready = 1'b0;
      in_data = 24'h700;
      check("fp_level", level, 0);
      check("fp_out_valid", out_valid, 0);
      check("fp_frame", frame_idx, 1);
      tick();
      in_valid = 1'b0;
      check("fp_head", out_data, 24'h700);
      check("fp_sof", sof, 1);
      check("fp_level1", level, 1);

      // Second frame returns frame_idx to 0.
      for (int i = 1; i < 8; i++) begin
         in_valid = 1'b1; in_data = 24'h700 + 24'(i);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("f2_data", out_data, 24'h700 + 24'(i));
         check("f2_eol", eol, (i == 3 || i == 7) ? 1 : 0);
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      check("f2_frame_back", frame_idx, 0);

      // Underrun after two pixels of a frame.
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 24'h800 + 24'(i);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("ur_level", level, 0);
      check("ur_not_yet", underrun, 0);
      tick();
      check("ur_set", underrun, 1);
      out_ready = 1'b0;
      tick();
      check("ur_sticky", underrun, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("ur_cleared", underrun, 0);
      in_valid = 1'b1; in_data = 24'h900;
      tick();
      check("ur_sof", sof, 1);
      check("ur_head", out_data, 24'h900);

      // Async reset mid-frame: head at x=1 with two pixels stored.
      in_data = 24'h901;
      tick();
      in_data = 24'h902; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("ar_pre_level", level, 2);
      check("ar_pre_sof", sof, 0);
      #2 rst = 1'b1;
      #1;
      check("ar_level", level, 0);
      check("ar_out_valid", out_valid, 0);
      check("ar_sof", sof, 0);
      check("ar_eol", eol, 0);
      check("ar_underrun", underrun, 0);
      check("ar_frame", frame_idx, 0);
      check("ar_in_ready", in_ready, 1);
      tick();
      rst = 1'b0;
      in_valid = 1'b1; in_data = 24'ha00;
      tick();
      in_valid = 1'b0;
      check("ar_post_level", level, 1);
      check("ar_post_head", out_data, 24'ha00);
      check("ar_post_sof", sof, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pixel_stream_bridge.md
PIXEL_STREAM_BRIDGE -- requirements
Module: pixel_stream_bridge

Interface
REQ-001 The block SHALL have parameter PIXEL_W, default 24, pixel data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-003 The block SHALL have parameter H_RES, default 320, pixels per line.
REQ-004 The block SHALL have parameter V_RES, default 240, lines per frame.
REQ-005 The block SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port flush_i, input, 1 bit: synchronous flush request.
REQ-008 The block SHALL have port in_valid_i, input, 1 bit: upstream pixel valid.
REQ-009 The block SHALL have port in_ready_o, output, 1 bit: the block can accept a pixel.
REQ-010 The block SHALL have port in_data_i, input, PIXEL_W bits: upstream pixel.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit: head pixel valid.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit: display accepts the head pixel.
REQ-013 The block SHALL have port out_data_o, output, PIXEL_W bits: head pixel.
REQ-014 The block SHALL have port out_sof_o, output, 1 bit: head pixel is at x=0, y=0.
REQ-015 The block SHALL have port out_eol_o, output, 1 bit: head pixel is at x=H_RES-1.
REQ-016 The block SHALL have port frame_idx_o, output, 1 bit: toggles once per completed frame.
REQ-017 The block SHALL have port level_o, output, $clog2(DEPTH+1) bits: FIFO occupancy.
REQ-018 The block SHALL have port underrun_o, output, 1 bit: sticky mid-frame starvation flag.

Function
REQ-019 A push SHALL occur on a cycle with in_valid_i=1 and in_ready_o=1; a pop SHALL occur on a cycle with out_valid_o=1 and out_ready_i=1.
REQ-020 in_ready_o SHALL equal (level_o != DEPTH) and !flush_i; it SHALL depend combinationally only on registered state and flush_i, never on in_valid_i.
REQ-021 out_valid_o SHALL equal (level_o != 0), and out_data_o SHALL present the oldest stored pixel (show-ahead).
REQ-022 A pixel pushed in cycle N SHALL be visible at the head no earlier than cycle N+1; there is no combinational input-to-output path.
REQ-023 level_o SHALL increase by 1 on push only, decrease by 1 on pop only, and stay unchanged on a simultaneous push and pop, including at level_o=1 and at level_o=DEPTH-1.
REQ-024 When full, no push SHALL occur; a pop in that cycle SHALL free one entry, visible as in_ready_o=1 in the next cycle.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH with no loss or reordering of data.
REQ-026 Registered counters x (0..H_RES-1) and y (0..V_RES-1) SHALL give the coordinate of the head pixel and SHALL advance only on a pop.
REQ-027 On a pop with x=H_RES-1, x SHALL become 0 and y SHALL increment; otherwise x SHALL increment.
REQ-028 On a pop at x=H_RES-1 and y=V_RES-1, x and y SHALL become 0 and frame_idx_o SHALL toggle in the next cycle.
REQ-029 out_sof_o SHALL be (x==0 && y==0) && out_valid_o, and out_eol_o SHALL be (x==H_RES-1) && out_valid_o.
REQ-030 underrun_o SHALL be set when out_ready_i=1, level_o=0 and (x!=0 || y!=0), and SHALL stay set until flush or reset.
REQ-031 With flush_i=1, the next state SHALL be level 0, pointers 0, x=y=0 and underrun_o=0; frame_idx_o SHALL be unchanged; flush SHALL override any push or pop in the same cycle, and no data SHALL be accepted in that cycle.

Reset
REQ-032 While rst_i=1, the block SHALL hold level_o=0, pointers 0, x=y=0, frame_idx_o=0, underrun_o=0, out_valid_o=0, out_sof_o=0 and out_eol_o=0; in_ready_o SHALL equal !flush_i.
REQ-033 Reset asserted mid-frame or mid-transfer SHALL discard all stored pixels immediately; FIFO storage contents need not be cleared.
REQ-034 After rst_i deasserts, the first pop SHALL be treated as x=0, y=0.

Verification
REQ-035 Fill test: reset, DEPTH=16, push 16 pixels with out_ready_i=0 -> level_o=16, in_ready_o=0; 17th pixel held off; pops return the data in push order.
REQ-036 Simultaneous test: level_o=DEPTH with push and pop in one cycle -> no push accepted, level_o=DEPTH-1 in the next cycle; at level_o=5 with push and pop together -> level_o stays 5.
REQ-037 Frame test: H_RES=4, V_RES=2, stream 8 pixels -> out_sof_o on pixel 0, out_eol_o on pixels 3 and 7, frame_idx_o 0->1 the cycle after pixel 7; 16 pixels -> frame_idx_o back to 0.
REQ-038 Underrun test: pop 2 pixels of a frame, then out_ready_i=1 with FIFO empty -> underrun_o=1 next cycle and stays 1; flush_i pulse -> underrun_o=0, next head out_sof_o=1.
REQ-039 Flush priority test: flush_i together with a push and a pop at level_o=3 -> level_o=0 next cycle, pushed pixel discarded, frame_idx_o unchanged.
REQ-040 Async reset test: assert rst_i between clock edges mid-frame -> outputs take their reset values before the next edge; after release, the first pixel carries out_sof_o=1.
